w0rm_memory_arbiter: RTL and testbench

W0RM_MEMORY_ARBITER -- requirements
Module: w0rm_memory_arbiter

---
 rtl/w0rm_memory_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_w0rm_memory_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_memory_arbiter.sv
// Two-port memory arbiter with lock support and one-cycle response routing.
// Optional build macro W0RM_ARBITER_ROUND_ROBIN_EN selects round-robin contention; default is fixed priority to port 0.
module w0rm_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  mem_clk,
  input  logic                  mem_rst_n,
  input  logic                  p0_valid_i,
  input  logic                  p0_read_i,
  input  logic                  p0_write_i,
  input  logic                  p0_lock_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_data_i,
  input  logic [USER_WIDTH-1:0] p0_user_i,
  output logic                  p0_ready_o,
  output logic                  p0_valid_o,
  output logic [DATA_WIDTH-1:0] p0_data_o,
  output logic [USER_WIDTH-1:0] p0_user_o,
  input  logic                  p1_valid_i,
  input  logic                  p1_read_i,
  input  logic                  p1_write_i,
  input  logic                  p1_lock_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_data_i,
  input  logic [USER_WIDTH-1:0] p1_user_i,
  output logic                  p1_ready_o,
  output logic                  p1_valid_o,
  output logic [DATA_WIDTH-1:0] p1_data_o,
  output logic [USER_WIDTH-1:0] p1_user_o,
  output logic                  mem_valid_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [USER_WIDTH-1:0] mem_user_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [USER_WIDTH-1:0] mem_user_i,
  output logic                  err_o
);

  localparam int CW = $clog2(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt;
  logic [CW-1:0] lock_cnt_r;
  logic [CW-1:0] lock_cnt_nxt;
  logic          prio_r;
  logic          prio_nxt;
  logic          route_r;
  logic          pend_r;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          gid;
  logic          gnt_lock;
  logic          own_valid;
  logic          own_lock;
  logic          forced;

  // Grant selection; prio_r names the port that wins an IDLE contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!mem_rst_n) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (p0_valid_i && p1_valid_i) begin
            grant0 = ~prio_r;
            grant1 = prio_r;
          end else begin
            grant0 = p0_valid_i;
            grant1 = p1_valid_i;
          end
        end
        LOCK0:   grant0 = p0_valid_i;
        LOCK1:   grant1 = p1_valid_i;
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  assign accept    = grant0 | grant1;
  assign gid       = grant1;
  assign gnt_lock  = gid ? p1_lock_i : p0_lock_i;
  assign own_valid = (state_r == LOCK1) ? p1_valid_i : p0_valid_i;
  assign own_lock  = (state_r == LOCK1) ? p1_lock_i  : p0_lock_i;

  // Lock FSM next state, lock counter and contention priority.
  always_comb begin
    state_nxt    = state_r;
    lock_cnt_nxt = lock_cnt_r;
    forced       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept && gnt_lock) begin
          state_nxt    = gid ? LOCK1 : LOCK0;
          lock_cnt_nxt = {CW{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end
      LOCK0, LOCK1: begin
        if (!own_valid || !own_lock) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = {CW{1'b0}};
        end else if (lock_cnt_r == CW'(MAX_LOCK - 2)) begin
          // This grant brings the run to MAX_LOCK; hand the next arbitration to the other port.
          state_nxt    = IDLE;
          lock_cnt_nxt = {CW{1'b0}};
          forced       = 1'b1;
        end else begin
          lock_cnt_nxt = lock_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = {CW{1'b0}};
      end
    endcase

    if (!accept) begin
      prio_nxt = prio_r;
    end else if (forced) begin
      prio_nxt = ~gid;
    end else begin
`ifdef W0RM_ARBITER_ROUND_ROBIN_EN
      prio_nxt = ~gid;
`else
      prio_nxt = 1'b0;
`endif
    end
  end

  // State, counter, priority and response-tracking registers.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_r    <= IDLE;
      lock_cnt_r <= {CW{1'b0}};
      prio_r     <= 1'b0;
      route_r    <= 1'b0;
      pend_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      lock_cnt_r <= lock_cnt_nxt;
      prio_r     <= prio_nxt;
      pend_r     <= accept;
      if (accept) begin
        route_r <= gid;
      end else begin
        route_r <= route_r;
      end
    end
  end

  // Request mux; an ungranted port's fields never reach memory.
  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = {ADDR_WIDTH{1'b0}};
    mem_data_o  = {DATA_WIDTH{1'b0}};
    mem_user_o  = {USER_WIDTH{1'b0}};
    if (grant1) begin
      mem_read_o  = p1_read_i;
      mem_write_o = p1_write_i;
      mem_addr_o  = p1_addr_i;
      mem_data_o  = p1_data_i;
      mem_user_o  = p1_user_i;
    end else if (grant0) begin
      mem_read_o  = p0_read_i;
      mem_write_o = p0_write_i;
      mem_addr_o  = p0_addr_i;
      mem_data_o  = p0_data_i;
      mem_user_o  = p0_user_i;
    end else begin
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
    end
  end

  assign mem_valid_o = accept;
  assign p0_ready_o  = grant0;
  assign p1_ready_o  = grant1;

  assign p0_valid_o = mem_rst_n & pend_r & mem_valid_i & ~route_r;
  assign p1_valid_o = mem_rst_n & pend_r & mem_valid_i & route_r;
  assign err_o      = mem_rst_n & pend_r & ~mem_valid_i;
  assign p0_data_o  = mem_data_i;
  assign p1_data_o  = mem_data_i;
  assign p0_user_o  = mem_user_i;
  assign p1_user_o  = mem_user_i;

endmodule

// File: tb/tb_w0rm_memory_arbiter.sv
// Scoreboard bench for w0rm_memory_arbiter: expected responses are queued when a grant is expected
// and compared one cycle later; a small memory model answers addresses at or above 0x4000_0000.
module tb_w0rm_memory_arbiter;

  logic        mem_clk = 1'b0;
  logic        mem_rst_n = 1'b0;
  logic        p0_valid_i = 1'b0, p0_read_i = 1'b0, p0_write_i = 1'b0, p0_lock_i = 1'b0;
  logic [31:0] p0_addr_i = 32'h0, p0_data_i = 32'h0, p0_user_i = 32'h0;
  logic        p1_valid_i = 1'b0, p1_read_i = 1'b0, p1_write_i = 1'b0, p1_lock_i = 1'b0;
  logic [31:0] p1_addr_i = 32'h0, p1_data_i = 32'h0, p1_user_i = 32'h0;
  logic        p0_ready_o, p0_valid_o, p1_ready_o, p1_valid_o;
  logic [31:0] p0_data_o, p0_user_o, p1_data_o, p1_user_o;
  logic        mem_valid_o, mem_read_o, mem_write_o, err_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_user_o;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_data_i = 32'h0, mem_user_i = 32'h0;
  logic        inject = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0] drv_addr [2];
  logic [31:0] drv_data [2];
  logic [31:0] drv_user [2];

  typedef struct {
    bit          any;
    bit          port;
    bit          err;
    logic [31:0] data;
    logic [31:0] user;
  } resp_t;

  resp_t sb [$];

  w0rm_memory_arbiter dut (
    .mem_clk(mem_clk), .mem_rst_n(mem_rst_n),
    .p0_valid_i(p0_valid_i), .p0_read_i(p0_read_i), .p0_write_i(p0_write_i), .p0_lock_i(p0_lock_i),
    .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i), .p0_user_i(p0_user_i),
    .p0_ready_o(p0_ready_o), .p0_valid_o(p0_valid_o), .p0_data_o(p0_data_o), .p0_user_o(p0_user_o),
    .p1_valid_i(p1_valid_i), .p1_read_i(p1_read_i), .p1_write_i(p1_write_i), .p1_lock_i(p1_lock_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_user_i(p1_user_i),
    .p1_ready_o(p1_ready_o), .p1_valid_o(p1_valid_o), .p1_data_o(p1_data_o), .p1_user_o(p1_user_o),
    .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_user_o(mem_user_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_user_i(mem_user_i),
    .err_o(err_o)
  );

  always #5 mem_clk = ~mem_clk;

  // Memory model: responds one cycle later to in-range addresses; inject forces a stray response.
  always @(posedge mem_clk) begin
    mem_valid_i <= inject | (mem_valid_o & (mem_addr_o >= 32'h4000_0000));
    mem_data_i  <= mem_addr_o ^ 32'h5A5A_0000;
    mem_user_i  <= mem_user_o;
  end

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic drv(input int n, input logic v, input logic wr, input logic lk,
                     input logic [31:0] a, input logic [31:0] u);
    drv_addr[n] = a;
    drv_user[n] = u;
    drv_data[n] = a ^ 32'h0F0F_0F0F;
    if (n == 0) begin
      p0_valid_i = v; p0_read_i = v & ~wr; p0_write_i = v & wr; p0_lock_i = lk;
      p0_addr_i = a; p0_data_i = drv_data[n]; p0_user_i = u;
    end else begin
      p1_valid_i = v; p1_read_i = v & ~wr; p1_write_i = v & wr; p1_lock_i = lk;
      p1_addr_i = a; p1_data_i = drv_data[n]; p1_user_i = u;
    end
  endtask

  task automatic idle_all();
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One cycle: check grant g (-1 none) and the previous cycle's response, then queue this cycle's.
  task automatic step(input int g);
    resp_t e;
    resp_t n;
    bit    v0;
    bit    v1;
    @(negedge mem_clk);
    chk_eq("p0_ready", p0_ready_o, g == 0);
    chk_eq("p1_ready", p1_ready_o, g == 1);
    chk_eq("mem_valid", mem_valid_o, g >= 0);
    if (g >= 0) begin
      chk_eq("mem_addr", mem_addr_o, drv_addr[g]);
      chk_eq("mem_data", mem_data_o, drv_data[g]);
      chk_eq("mem_user", mem_user_o, drv_user[g]);
    end
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      v0 = e.any && !e.err && !e.port;
      v1 = e.any && !e.err && e.port;
      chk_eq("resp_valid0", p0_valid_o, v0);
      chk_eq("resp_valid1", p1_valid_o, v1);
      chk_eq("resp_err", err_o, e.any && e.err);
      if (v0 || v1) begin
        chk_eq("resp_user", v1 ? p1_user_o : p0_user_o, e.user);
        chk_eq("resp_data", v1 ? p1_data_o : p0_data_o, e.data);
      end
    end
    n.any  = (g >= 0);
    n.port = (g == 1);
    n.err  = (g >= 0) && (drv_addr[g == 1] < 32'h4000_0000);
    n.data = drv_addr[g == 1] ^ 32'h5A5A_0000;
    n.user = drv_user[g == 1];
    sb.push_back(n);
    @(posedge mem_clk);
    #1;
  endtask

  initial begin
    int exp_g;
    drv(0, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'h1);
    drv(1, 1'b1, 1'b0, 1'b0, 32'h4000_0004, 32'h2);
    #12;
    chk_eq("rst_p0_ready", p0_ready_o, 1'b0);
    chk_eq("rst_p1_ready", p1_ready_o, 1'b0);
    chk_eq("rst_mem_valid", mem_valid_o, 1'b0);
    chk_eq("rst_valid_o", {p0_valid_o, p1_valid_o, err_o}, 3'b000);
    @(posedge mem_clk);
    #1;
    idle_all();
    mem_rst_n = 1'b1;

    // Single p0 read, then single p1 read.
    drv(0, 1'b1, 1'b0, 1'b0, 32'h4000_0004, 32'hA5);
    step(0);
    idle_all();
    drv(1, 1'b1, 1'b0, 1'b0, 32'h4000_0010, 32'hB1);
    step(1);
    idle_all();
    step(-1);

    // Both ports requesting for four consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      drv(0, 1'b1, 1'b0, 1'b0, 32'h4000_1000 + 32'(i * 16), 32'hC0 + 32'(i));
      drv(1, 1'b1, 1'b0, 1'b0, 32'h4000_2000 + 32'(i * 16), 32'hD0 + 32'(i));
`ifdef W0RM_ARBITER_ROUND_ROBIN_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      step(exp_g);
    end
    idle_all();
    step(-1);

    // p1 write outside memory raises a one-cycle error.
    drv(1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'hE1);
    step(1);
    idle_all();
    step(-1);
    step(-1);

    // p0 holds lock for 20 cycles while p1 keeps requesting.
    for (int i = 0; i < 20; i++) begin
      drv(0, 1'b1, 1'b0, 1'b1, 32'h4000_0100 + 32'(i * 4), 32'h100 + 32'(i));
      drv(1, 1'b1, 1'b0, 1'b0, 32'h4000_0200 + 32'(i * 4), 32'h200 + 32'(i));
      step((i == 16) ? 1 : 0);
    end
    idle_all();
    step(-1);
    step(-1);

    // Lock released by the owner dropping valid; p1 blocked until then.
    drv(0, 1'b1, 1'b0, 1'b1, 32'h4000_0300, 32'h31);
    step(0);
    drv(0, 1'b1, 1'b0, 1'b1, 32'h4000_0304, 32'h32);
    drv(1, 1'b1, 1'b0, 1'b0, 32'h4000_0400, 32'h41);
    step(0);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(-1);
    step(1);
    idle_all();
    step(-1);

    // Alternating single requests, one accepted per cycle.
    for (int i = 0; i < 6; i++) begin
      idle_all();
      drv(i % 2, 1'b1, (i == 3), 1'b0, 32'h4000_0500 + 32'(i * 8), 32'h50 + 32'(i));
      step(i % 2);
    end
    idle_all();
    step(-1);

    // Reset during the response cycle of a locked p0 read.
    drv(0, 1'b1, 1'b0, 1'b1, 32'h4000_0040, 32'h31);
    step(0);
    mem_rst_n = 1'b0;
    sb.delete();
    inject = 1'b1;
    @(negedge mem_clk);
    chk_eq("rst_resp_p0_valid", p0_valid_o, 1'b0);
    chk_eq("rst_resp_p1_valid", p1_valid_o, 1'b0);
    chk_eq("rst_resp_err", err_o, 1'b0);
    chk_eq("rst_resp_ready", {p0_ready_o, p1_ready_o, mem_valid_o}, 3'b000);
    @(posedge mem_clk);
    #1;
    mem_rst_n = 1'b1;
    idle_all();
    @(negedge mem_clk);
    chk_eq("stray_valid", {p0_valid_o, p1_valid_o, err_o}, 3'b000);
    @(posedge mem_clk);
    #1;
    inject = 1'b0;
    drv(1, 1'b1, 1'b0, 1'b0, 32'h4000_0050, 32'h51);
    step(1);
    drv(0, 1'b1, 1'b0, 1'b0, 32'h4000_0060, 32'h61);
    drv(1, 1'b1, 1'b0, 1'b0, 32'h4000_0070, 32'h71);
    step(0);
    idle_all();
    step(-1);
    step(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
